// File: rtl/zap_memory_skid.sv
// rtl/zap_memory_skid.sv - DEPTH-entry in-order memory stage buffer; loads complete on i_mem_ack.
// Optional macro ZAP_MEM_MISALIGN_ROT_EN: misaligned word loads return the lane rotated right.
module zap_memory_skid #(
    parameter int FLAG_WDT = 32,
    parameter int PHY_REGS = 46,
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_clear_from_writeback,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [31:0]                 i_alu_result_ff,
    input  logic [FLAG_WDT-1:0]         i_flags_ff,
    input  logic                        i_flag_update_ff,
    input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
    input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
    input  logic [DATA_WDT-1:0]         i_mem_srcdest_value_ff,
    input  logic [31:0]                 i_pc_plus_8_ff,
    input  logic                        i_irq_ff,
    input  logic                        i_fiq_ff,
    input  logic                        i_swi_ff,
    input  logic                        i_instr_abort_ff,
    input  logic                        i_und_ff,
    input  logic                        i_mem_load_ff,
    input  logic [2:0]                  i_size,
    input  logic                        i_mem_ack,
    input  logic [DATA_WDT-1:0]         i_mem_rd_data,
    input  logic                        i_mem_fault,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [31:0]                 o_alu_result_ff,
    output logic [FLAG_WDT-1:0]         o_flags_ff,
    output logic                        o_flag_update_ff,
    output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
    output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
    output logic [31:0]                 o_pc_plus_8_ff,
    output logic                        o_irq_ff,
    output logic                        o_fiq_ff,
    output logic                        o_swi_ff,
    output logic                        o_instr_abort_ff,
    output logic                        o_und_ff,
    output logic                        o_mem_load_ff,
    output logic                        o_mem_fault,
    output logic [DATA_WDT-1:0]         o_mem_rd_data_ff
);
    localparam int IW = $clog2(PHY_REGS);
    localparam int OW = $clog2(DATA_WDT / 8);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = PW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]         alu;
        logic [FLAG_WDT-1:0] flags;
        logic                flag_update;
        logic [IW-1:0]       dest;
        logic [IW-1:0]       srcdest_idx;
        logic [DATA_WDT-1:0] data;
        logic [31:0]         pc8;
        logic                irq;
        logic                fiq;
        logic                swi;
        logic                iabt;
        logic                und;
        logic                load;
        logic                fault;
        logic                have_data;
        logic [2:0]          size;
    } entry_t;

    entry_t        ent_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, drop_cnt_q, drop_cnt_d;
    entry_t        new_ent;
    logic          push, pop, found, fill_old, fill_new;
    logic [PW-1:0] fill_idx;
    logic [CW-1:0] pend;
    logic [SW-1:0] slot;
    logic [CW:0]   drop_sum;

    // Alignment is driven by the load address, never by the returned data.
    function automatic logic [DATA_WDT-1:0] align(input logic [DATA_WDT-1:0] d,
                                                  input logic [OW-1:0] off,
                                                  input logic [2:0] sz);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = 8'(d >> {off, 3'b000});
        h = 16'(d >> {(off & ~OW'(1)), 3'b000});
        w = 32'(d >> {(off & ~OW'(3)), 3'b000});
`ifdef ZAP_MEM_MISALIGN_ROT_EN
        w = 32'({w, w} >> {off[1:0], 3'b000});
`endif
        case (sz)
            3'd1:    align = DATA_WDT'(b);
            3'd2:    align = {{(DATA_WDT-8){b[7]}}, b};
            3'd3:    align = DATA_WDT'(h);
            3'd4:    align = {{(DATA_WDT-16){h[15]}}, h};
            3'd5:    align = (DATA_WDT == 64) ? d : DATA_WDT'(w);
            default: align = DATA_WDT'(w);
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_ready = (count_q < CW'(DEPTH));
    assign o_valid = (count_q != '0) && ent_q[rd_ptr_q].have_data;

    always_comb begin
        push     = i_valid && o_ready && !i_clear_from_writeback;
        pop      = o_valid && i_ready;
        found    = 1'b0;
        fill_idx = '0;
        pend     = '0;
        slot     = '0;
        // Walk youngest to oldest so the last hit is the oldest pending load.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            slot = {1'b0, rd_ptr_q} + SW'(i);
            if (slot >= SW'(DEPTH)) slot = slot - SW'(DEPTH);
            if ((CW'(i) < count_q) && ent_q[slot[PW-1:0]].load && !ent_q[slot[PW-1:0]].have_data) begin
                found    = 1'b1;
                fill_idx = slot[PW-1:0];
                pend     = pend + CW'(1);
            end
        end
        fill_old = i_mem_ack && (drop_cnt_q == '0) && found;
        fill_new = i_mem_ack && (drop_cnt_q == '0) && !found && push && i_mem_load_ff;

        new_ent             = '0;
        new_ent.alu         = i_alu_result_ff;
        new_ent.flags       = i_flags_ff;
        new_ent.flag_update = i_flag_update_ff;
        new_ent.dest        = i_destination_index_ff;
        new_ent.srcdest_idx = i_mem_srcdest_index_ff;
        new_ent.data        = fill_new ? align(i_mem_rd_data, i_alu_result_ff[OW-1:0], i_size)
                                       : i_mem_srcdest_value_ff;
        new_ent.pc8         = i_pc_plus_8_ff;
        new_ent.irq         = i_irq_ff;
        new_ent.fiq         = i_fiq_ff;
        new_ent.swi         = i_swi_ff;
        new_ent.iabt        = i_instr_abort_ff;
        new_ent.und         = i_und_ff;
        new_ent.load        = i_mem_load_ff;
        new_ent.fault       = fill_new && i_mem_fault;
        new_ent.have_data   = !i_mem_load_ff || fill_new;
        new_ent.size        = i_size;

        drop_sum = '0;
        if (i_clear_from_writeback) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            // An ack in the flush cycle is charged against the loads being dropped.
            drop_sum = {1'b0, drop_cnt_q} + {1'b0, pend};
            if (i_mem_ack && (drop_sum != '0)) drop_sum = drop_sum - (CW+1)'(1);
            drop_cnt_d = (drop_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : drop_sum[CW-1:0];
        end else begin
            count_d    = count_q + CW'(push) - CW'(pop);
            rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            drop_cnt_d = drop_cnt_q - CW'(i_mem_ack && (drop_cnt_q != '0));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if (!i_clear_from_writeback) begin
                if (push) ent_q[wr_ptr_q] <= new_ent;
                if (fill_old) begin
                    ent_q[fill_idx].data      <= align(i_mem_rd_data, ent_q[fill_idx].alu[OW-1:0],
                                                       ent_q[fill_idx].size);
                    ent_q[fill_idx].fault     <= i_mem_fault;
                    ent_q[fill_idx].have_data <= 1'b1;
                end
            end
        end
    end

    assign o_alu_result_ff        = ent_q[rd_ptr_q].alu;
    assign o_flags_ff             = ent_q[rd_ptr_q].flags;
    assign o_flag_update_ff       = ent_q[rd_ptr_q].flag_update;
    assign o_destination_index_ff = ent_q[rd_ptr_q].dest;
    assign o_mem_srcdest_index_ff = ent_q[rd_ptr_q].srcdest_idx;
    assign o_pc_plus_8_ff         = ent_q[rd_ptr_q].pc8;
    assign o_irq_ff               = ent_q[rd_ptr_q].irq;
    assign o_fiq_ff               = ent_q[rd_ptr_q].fiq;
    assign o_swi_ff               = ent_q[rd_ptr_q].swi;
    assign o_instr_abort_ff       = ent_q[rd_ptr_q].iabt;
    assign o_und_ff               = ent_q[rd_ptr_q].und;
    assign o_mem_load_ff          = ent_q[rd_ptr_q].load;
    assign o_mem_fault            = ent_q[rd_ptr_q].fault;
    assign o_mem_rd_data_ff       = ent_q[rd_ptr_q].data;
endmodule

// File: tb/tb_zap_memory_skid.sv
// tb/tb_zap_memory_skid.sv - queue-model scoreboard bench for zap_memory_skid (DEPTH=3, 32-bit data).
module tb_zap_memory_skid;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear, i_valid, o_ready, fu, irq, fiq, swi, iabt, und, load, mem_ack, mem_fault;
    logic        o_valid, i_ready, o_fu, o_irq, o_fiq, o_swi, o_iabt, o_und, o_load, o_fault;
    logic [31:0] alu, flags, sval, pc8, rd_data, o_alu, o_flags, o_pc8, o_data;
    logic [5:0]  dest, sidx, o_dest, o_sidx;
    logic [2:0]  size;

    typedef struct {
        logic [31:0] alu, flags, pc8, data;
        logic [5:0]  dest, sidx;
        logic        fu, irq, fiq, swi, iabt, und, ld, flt, have;
        logic [2:0]  sz;
    } ent_t;

    ent_t mq[$];
    int   drop = 0;
    logic acc_q = 1'b0;
    logic exp_valid;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    zap_memory_skid #(.FLAG_WDT(32), .PHY_REGS(46), .DATA_WDT(32), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear_from_writeback(clear),
        .i_valid(i_valid), .o_ready(o_ready), .i_alu_result_ff(alu), .i_flags_ff(flags),
        .i_flag_update_ff(fu), .i_destination_index_ff(dest), .i_mem_srcdest_index_ff(sidx),
        .i_mem_srcdest_value_ff(sval), .i_pc_plus_8_ff(pc8), .i_irq_ff(irq), .i_fiq_ff(fiq),
        .i_swi_ff(swi), .i_instr_abort_ff(iabt), .i_und_ff(und), .i_mem_load_ff(load),
        .i_size(size), .i_mem_ack(mem_ack), .i_mem_rd_data(rd_data), .i_mem_fault(mem_fault),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_result_ff(o_alu), .o_flags_ff(o_flags),
        .o_flag_update_ff(o_fu), .o_destination_index_ff(o_dest), .o_mem_srcdest_index_ff(o_sidx),
        .o_pc_plus_8_ff(o_pc8), .o_irq_ff(o_irq), .o_fiq_ff(o_fiq), .o_swi_ff(o_swi),
        .o_instr_abort_ff(o_iabt), .o_und_ff(o_und), .o_mem_load_ff(o_load),
        .o_mem_fault(o_fault), .o_mem_rd_data_ff(o_data)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte/half/word extraction from the address offset, written as plain arithmetic.
    function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [31:0] addr,
                                              input logic [2:0] sz);
        int off;
        logic [31:0] b, h;
        off = int'(addr % 4);
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * (off / 2))) & 32'hFFFF;
        case (sz)
            3'd1: return b;
            3'd2: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd3: return h;
            3'd4: return h[15] ? (h | 32'hFFFF_0000) : h;
            default: begin
`ifdef ZAP_MEM_MISALIGN_ROT_EN
                return (off == 0) ? d : ((d >> (8 * off)) | (d << (32 - 8 * off)));
`else
                return d;
`endif
            end
        endcase
    endfunction

    function automatic bit has_unfilled();
        foreach (mq[i]) if (mq[i].ld && !mq[i].have) return 1'b1;
        return 1'b0;
    endfunction

    // Apply the effects of the inputs that were held during the cycle that just ended.
    task automatic commit();
        ent_t e;
        int   n;
        if (clear) begin
            n = drop;
            foreach (mq[i]) if (mq[i].ld && !mq[i].have) n++;
            if (mem_ack && n > 0) n--;
            drop = (n > DEPTH) ? DEPTH : n;
            mq.delete();
        end else begin
            if (acc_q) begin
                e.alu = alu; e.flags = flags; e.pc8 = pc8; e.dest = dest; e.sidx = sidx;
                e.fu = fu; e.irq = irq; e.fiq = fiq; e.swi = swi; e.iabt = iabt; e.und = und;
                e.ld = load; e.sz = size; e.flt = 1'b0;
                e.have = !load;
                e.data = load ? 32'h0 : sval;
                mq.push_back(e);
            end
            if (mem_ack) begin
                if (drop > 0) drop--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].ld && !mq[i].have) begin
                            e = mq[i];
                            e.data = ref_align(rd_data, e.alu, e.sz);
                            e.flt = mem_fault;
                            e.have = 1'b1;
                            mq[i] = e;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic ld, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] val, input logic ack, input logic [31:0] ad,
                        input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        commit();
        i_valid = v; load = ld; size = sz; alu = addr; sval = val;
        mem_ack = ack; rd_data = ad; i_ready = rdy; clear = fl;
        flags = $urandom; fu = 1'($urandom); pc8 = $urandom;
        dest = 6'($urandom_range(0, 45)); sidx = 6'($urandom_range(0, 45));
        {irq, fiq, swi, iabt, und} = 5'($urandom);
        mem_fault = 1'($urandom);
        acc_q = v && !fl && (mq.size() < DEPTH);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    task automatic zero_inputs();
        {clear, i_valid, fu, irq, fiq, swi, iabt, und, load, mem_ack, mem_fault, i_ready} = '0;
        {alu, flags, sval, pc8, rd_data} = '0;
        dest = '0; sidx = '0; size = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            exp_valid = (mq.size() != 0) && mq[0].have;
            check("o_ready", 128'(o_ready), 128'(mq.size() < DEPTH));
            check("o_valid", 128'(o_valid), 128'(exp_valid));
            if (exp_valid) begin
                check("alu", 128'(o_alu), 128'(mq[0].alu));
                check("rd_data", 128'(o_data), 128'(mq[0].data));
                check("fault", 128'(o_fault), 128'(mq[0].flt));
                check("fields", 128'({o_flags, o_fu, o_dest, o_sidx, o_pc8, o_irq, o_fiq, o_swi,
                                      o_iabt, o_und, o_load}),
                      128'({mq[0].flags, mq[0].fu, mq[0].dest, mq[0].sidx, mq[0].pc8, mq[0].irq,
                            mq[0].fiq, mq[0].swi, mq[0].iabt, mq[0].und, mq[0].ld}));
                if (i_ready) void'(mq.pop_front());
            end
        end
    end

    initial begin
        zero_inputs();
        #12;
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_ready", 128'(o_ready), 128'(1));
        check("rst_alu", 128'(o_alu), 128'(0));
        check("rst_data", 128'(o_data), 128'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Non-load appears one cycle after push with its pass-through value.
        step(1, 0, 3'd0, 32'h1234, 32'hCAFE_0001, 0, 0, 1, 0);
        idle(1);
        check("nl_valid", 128'(o_valid), 128'(1));
        check("nl_alu", 128'(o_alu), 128'(32'h1234));
        check("nl_data", 128'(o_data), 128'(32'hCAFE_0001));

        // Signed byte load at offset 3, acked two cycles after push.
        step(1, 1, 3'd2, 32'h0000_1003, 0, 0, 0, 1, 0);
        idle(1);
        step(0, 0, 3'd0, 0, 0, 1, 32'h80FF_0000, 1, 0);
        check("sb_wait", 128'(o_valid), 128'(0));
        idle(1);
        check("sb_valid", 128'(o_valid), 128'(1));
        check("sb_data", 128'(o_data), 128'(32'hFFFF_FF80));

        // Misaligned word load.
        step(1, 1, 3'd0, 32'h0000_2001, 0, 1, 32'h4433_2211, 1, 0);
        idle(1);
        check("wd_valid", 128'(o_valid), 128'(1));
`ifdef ZAP_MEM_MISALIGN_ROT_EN
        check("wd_data", 128'(o_data), 128'(32'h1144_3322));
`else
        check("wd_data", 128'(o_data), 128'(32'h4433_2211));
`endif

        // Fill to capacity, then a single pop reopens the buffer.
        for (int k = 0; k < DEPTH; k++) step(1, 0, 3'd0, 32'h100 + k, 32'h200 + k, 0, 0, 0, 0);
        idle(0);
        check("full_ready", 128'(o_ready), 128'(0));
        step(1, 0, 3'd0, 32'hDEAD, 32'hDEAD, 0, 0, 1, 0);
        idle(1);
        check("pop_ready", 128'(o_ready), 128'(1));
        repeat (DEPTH + 1) idle(1);

        // Two loads flushed before their acks; both late acks must be discarded.
        step(1, 1, 3'd0, 32'h3000, 0, 0, 0, 1, 0);
        step(1, 1, 3'd0, 32'h3004, 0, 0, 0, 1, 0);
        step(0, 0, 3'd0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 3'd0, 32'h3008, 32'h5A5A_5A5A, 1, 32'h1111_1111, 1, 0);
        step(0, 0, 3'd0, 0, 0, 1, 32'h2222_2222, 1, 0);
        check("fl_valid", 128'(o_valid), 128'(1));
        check("fl_data", 128'(o_data), 128'(32'h5A5A_5A5A));
        repeat (3) idle(1);

        for (int c = 0; c < 3000; c++) begin
            logic ack;
            ack = (drop > 0 || has_unfilled()) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 49) == 0);
            step(1'($urandom), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 5)), $urandom,
                 $urandom, ack, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        // Reset in the middle of an outstanding load; a later ack must be ignored.
        step(0, 0, 3'd0, 0, 0, 0, 0, 1, 1);
        idle(1);
        step(1, 1, 3'd0, 32'h4440, 0, 0, 0, 1, 0);
        idle(1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(o_valid), 128'(0));
        check("arst_ready", 128'(o_ready), 128'(1));
        check("arst_alu", 128'(o_alu), 128'(0));
        check("arst_data", 128'(o_data), 128'(0));
        zero_inputs();
        mq.delete();
        drop = 0;
        acc_q = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 3'd0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        repeat (3) idle(1);
        check("post_rst_valid", 128'(o_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
